// File: rtl/mc_data_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_data_sync_pkg
// Description : Shared definitions for the multi-channel data synchroniser:
//               legal parameter ranges, qualifier mode encoding and the
//               channel slice offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_data_sync_pkg;

  // Legal synchroniser depth and channel count
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int MIN_CH     = 1;
  localparam int MAX_CH     = 8;

  // Qualifier signalling: level (rising edge is the event) or toggle
  // (any transition is the event)
  typedef enum logic {
    MODE_LEVEL  = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  // Bit offset of channel ch inside a packed multi-channel bus
  function automatic int ch_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage : mc_data_sync_pkg
`default_nettype wire

// File: rtl/ds_channel.sv
`default_nettype none
// ============================================================================
// Module      : ds_channel
// Description : One synchroniser channel. Brings an asynchronous qualifier
//               through a NUM_STAGES flop chain, detects the event and
//               captures the accompanying data word into a valid/ready
//               output register with a 2-phase acknowledge back to source.
// Ports       : CLK, RST (async, active-low)
//               bus_enable_i   - asynchronous qualifier
//               data_i         - source data word (stable until ack seen)
//               ready_i        - consumer accepts the presented word
//               clr_overflow_i - clears the sticky overflow flag
//               data_o/valid_o - presented word
//               ack_o          - toggles once per captured word
//               overflow_o     - sticky: an event was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module ds_channel
  import mc_data_sync_pkg::*;
#(
  parameter int    NUM_STAGES = 2,
  parameter int    BUS_WIDTH  = 8,
  parameter mode_e MODE       = MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic                 ready_i,
  input  logic                 clr_overflow_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 ack_o,
  output logic                 overflow_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  last_q;      // previous synchronised qualifier
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic                  ovf_q, ovf_d;

  logic s;
  logic evt;
  logic accept;

  assign s      = sync_q[NUM_STAGES-1];
  assign evt    = (MODE == MODE_TOGGLE) ? (s ^ last_q) : (s & ~last_q);
  assign accept = valid_q & ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    ovf_d   = ovf_q;

    if (evt && (!valid_q || accept)) begin
      // Register is free (or freed this edge): take the new word
      data_d  = data_i;
      valid_d = 1'b1;
      ack_d   = ~ack_q;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    // Drop has priority over clear so a simultaneous loss is never hidden
    if (evt && valid_q && !ready_i) begin
      ovf_d = 1'b1;
    end else if (clr_overflow_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NUM_STAGES-2:0], bus_enable_i};
      last_q  <= s;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign ack_o      = ack_q;
  assign overflow_o = ovf_q;

endmodule : ds_channel
`default_nettype wire

// File: rtl/mc_data_sync.sv
`default_nettype none
// ============================================================================
// Module      : mc_data_sync
// Description : Multi-channel enable-qualified CDC synchroniser. NUM_CH fully
//               independent channels, each carrying BUS_WIDTH bits into the
//               CLK domain with a valid/ready output and 2-phase ack.
// Ports       : CLK, RST (async, active-low)
//               bus_enable   [NUM_CH]            - per-channel qualifier
//               Unsync_bus   [NUM_CH*BUS_WIDTH]  - source data, packed
//               sync_ready   [NUM_CH]            - consumer ready
//               clr_overflow [NUM_CH]            - clear sticky overflow
//               sync_bus     [NUM_CH*BUS_WIDTH]  - captured data, packed
//               sync_valid   [NUM_CH]            - word present
//               ack_toggle   [NUM_CH]            - acknowledge to source
//               overflow     [NUM_CH]            - sticky drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module mc_data_sync
  import mc_data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           clr_overflow,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           overflow
);

  localparam mode_e CH_MODE = (TOGGLE_MODE != 0) ? MODE_TOGGLE : MODE_LEVEL;

  generate
    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("mc_data_sync: NUM_STAGES out of range 2..4");
    end
    if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_ch
      $error("mc_data_sync: NUM_CH out of range 1..8");
    end
  endgenerate

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int OFF = ch_offset(c, BUS_WIDTH);

      ds_channel #(
        .NUM_STAGES (NUM_STAGES),
        .BUS_WIDTH  (BUS_WIDTH),
        .MODE       (CH_MODE)
      ) u_ch (
        .CLK            (CLK),
        .RST            (RST),
        .bus_enable_i   (bus_enable[c]),
        .data_i         (Unsync_bus[OFF +: BUS_WIDTH]),
        .ready_i        (sync_ready[c]),
        .clr_overflow_i (clr_overflow[c]),
        .data_o         (sync_bus[OFF +: BUS_WIDTH]),
        .valid_o        (sync_valid[c]),
        .ack_o          (ack_toggle[c]),
        .overflow_o     (overflow[c])
      );
    end
  endgenerate

endmodule : mc_data_sync
`default_nettype wire
